// File: rtl/axil_req_sequencer_if.sv
// axil_req_sequencer_if: request/completion handshake plus the level-strobe port
// towards the AXI-Lite master. The sequencer uses the slave modport, a requester the master one.
interface axil_req_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_data;
  logic [7:0]  req_tag;

  logic        cpl_valid;
  logic        cpl_ready;
  logic [7:0]  cpl_tag;
  logic        cpl_write;
  logic [31:0] cpl_data;
  logic [1:0]  cpl_status;

  logic [31:0] rd_addr;
  logic [3:0]  rd_be;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_data_valid;

  logic [31:0] wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        wr_busy;
  logic        wr_done;

  modport slave (
    input  req_valid, req_write, req_addr, req_be, req_data, req_tag,
    input  cpl_ready, rd_data, rd_data_valid, wr_done,
    output req_ready, cpl_valid, cpl_tag, cpl_write, cpl_data, cpl_status,
    output rd_addr, rd_be, rd_en, wr_addr, wr_be, wr_data, wr_en, wr_busy
  );

  modport master (
    output req_valid, req_write, req_addr, req_be, req_data, req_tag,
    output cpl_ready, rd_data, rd_data_valid, wr_done,
    input  req_ready, cpl_valid, cpl_tag, cpl_write, cpl_data, cpl_status,
    input  rd_addr, rd_be, rd_en, wr_addr, wr_be, wr_data, wr_en, wr_busy
  );
endinterface

// File: rtl/axil_req_sequencer.sv
// axil_req_sequencer: accepts one dword request at a time, drives the master's level strobes and
// returns a tagged completion. Define AXIL_REQ_TIMEOUT_EN to enable the forced-error watchdog.
module axil_req_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_CNT_W       = 16
) (
  input  logic                M_AXI_ACLK,
  input  logic                M_AXI_ARESET,
  axil_req_sequencer_if.slave bus,
  output logic [TO_CNT_W-1:0] stale_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd2;
  localparam logic [2:0] S_CPL     = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** TO_CNT_W) - 1) begin : g_cfg_err
    $error("TIMEOUT_CYCLES must be in 1 .. 2**TO_CNT_W-1");
  end

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic                r_req_ready;
  logic                r_write;
  logic [31:0]         r_addr;
  logic [3:0]          r_be;
  logic [31:0]         r_wdata;
  logic [7:0]          r_tag;
  logic                r_rd_en;
  logic                r_wr_en;
  logic                r_cpl_valid;
  logic [31:0]         r_cpl_data;
  logic [1:0]          r_cpl_status;
  logic [TO_CNT_W-1:0] r_stale_cnt;

  logic w_accept;
  logic w_in_wait;
  logic w_rd_resp;
  logic w_wr_resp;
  logic w_resp;
  logic w_expire;
  logic w_stale;

  assign w_accept  = bus.req_valid & r_req_ready;
  assign w_in_wait = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
  assign w_rd_resp = (r_state == S_RD_WAIT) & bus.rd_data_valid;
  assign w_wr_resp = (r_state == S_WR_WAIT) & bus.wr_done;
  assign w_resp    = w_rd_resp | w_wr_resp;
  // Any pulse that does not match the current wait state is a late or spurious response.
  assign w_stale   = (bus.rd_data_valid & ~w_rd_resp) | (bus.wr_done & ~w_wr_resp);

`ifdef AXIL_REQ_TIMEOUT_EN
  logic [TO_CNT_W-1:0] r_to_cnt;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_to_cnt <= '0;
    end else if (w_accept) begin
      r_to_cnt <= '0;
    end else if (w_in_wait) begin
      r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
    end
  end

  // A response in the expiry cycle takes priority: w_resp is checked first when completing.
  assign w_expire = w_in_wait && (r_to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = bus.req_write ? S_WR_WAIT : S_RD_WAIT;
      S_RD_WAIT: if (w_rd_resp || w_expire) w_state_nxt = S_CPL;
      S_WR_WAIT: if (w_wr_resp || w_expire) w_state_nxt = S_CPL;
      S_CPL:     if (bus.cpl_ready) w_state_nxt = S_GAP;
      S_GAP:     w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_tag        <= '0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_cpl_valid  <= 1'b0;
      r_cpl_data   <= '0;
      r_cpl_status <= ST_OK;
    end else begin
      r_state     <= w_state_nxt;
      // Registered from the next state so every output is low while reset is held.
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_rd_en     <= (w_state_nxt == S_RD_WAIT);
      r_wr_en     <= (w_state_nxt == S_WR_WAIT);

      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_be    <= bus.req_be;
        r_wdata <= bus.req_data;
        r_tag   <= bus.req_tag;
      end

      if (w_in_wait && (w_state_nxt == S_CPL)) begin
        r_cpl_valid  <= 1'b1;
        r_cpl_data   <= w_rd_resp ? bus.rd_data : 32'h0;
        r_cpl_status <= w_resp ? ST_OK : ST_TIMEOUT;
      end else if ((r_state == S_CPL) && bus.cpl_ready) begin
        r_cpl_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_stale_cnt <= '0;
    end else if (w_stale && (r_stale_cnt != '1)) begin
      r_stale_cnt <= r_stale_cnt + TO_CNT_W'(1);
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.cpl_valid  = r_cpl_valid;
  assign bus.cpl_tag    = r_tag;
  assign bus.cpl_write  = r_write;
  assign bus.cpl_data   = r_cpl_data;
  assign bus.cpl_status = r_cpl_status;
  assign bus.rd_addr    = r_addr;
  assign bus.rd_be      = r_be;
  assign bus.rd_en      = r_rd_en;
  assign bus.wr_addr    = r_addr;
  assign bus.wr_be      = r_be;
  assign bus.wr_data    = r_wdata;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_busy    = r_wr_en;
  assign stale_cnt      = r_stale_cnt;

endmodule
